count_sched: RTL and testbench

Round-robin controller sharing one saturating event counter among NREQ requesters. A requester raises `req`; when granted, the counter is cleared and then counts that requester's `ev` strobes. On the cycle after the counter is full (all ones) and one more event arrives, the requester gets a one-cycle `done` pulse and the grant is released. The block sits in front of the shared counter datapath and replaces per-client start/count control logic.

---
 rtl/count_sched_pkg.sv | 14 +
 rtl/sched_counter.sv | 28 ++
 rtl/count_sched.sv | 100 ++++++++++
 tb/tb_count_sched.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// Shared types and default sizing for the round-robin count scheduler.
package count_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/sched_counter.sv
// Saturating event counter with synchronous clear, shared by all requesters.
module sched_counter
  import count_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  assign full = (cnt == {CNT_W{1'b1}});

  // Saturates at all-ones; the scheduler treats the next strobe as completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !full) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/count_sched.sv
// Round-robin grant FSM in front of the shared event counter.
// Define COUNT_SCHED_ABORT_EN to release the grant when the owner drops req.
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  ev,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic [NREQ-1:0]  done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t     state, next_state;
  logic [IDX_W-1:0] ptr, g_idx, pick_idx, scan_idx, next_ptr;
  logic             pick_valid, cnt_clear, cnt_en, full;

  sched_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (cnt_en),
    .cnt   (cnt),
    .full  (full)
  );

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = IDX_W'((int'(ptr) + i) % NREQ);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign next_ptr = (g_idx == IDX_W'(NREQ - 1)) ? '0 : g_idx + IDX_W'(1);
  assign busy     = (state != IDLE);

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    unique case (state)
      IDLE:  if (pick_valid) next_state = CLEAR;
      CLEAR: begin
        cnt_clear  = 1'b1;
        next_state = COUNT;
      end
      COUNT: begin
        if (ev[g_idx]) begin
          if (full) next_state = DONE;
          else      cnt_en     = 1'b1;
        end
      end
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
`ifdef COUNT_SCHED_ABORT_EN
    // An abandoned run leaves the counter untouched for whoever inspects it.
    if ((state == CLEAR || state == COUNT) && !req[g_idx]) begin
      next_state = IDLE;
      cnt_clear  = 1'b0;
      cnt_en     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      g_idx <= '0;
      gnt   <= '0;
      done  <= '0;
    end else begin
      state <= next_state;
      done  <= (next_state == DONE) ? (NREQ'(1) << g_idx) : '0;
      if (state == IDLE && pick_valid) begin
        g_idx <= pick_idx;
        gnt   <= NREQ'(1) << pick_idx;
      end else if (state != IDLE && next_state == IDLE) begin
        gnt <= '0;
        ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_count_sched.sv
// Directed self-checking bench for count_sched (NREQ=4, CNT_W=4).
module tb_count_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ev;
  logic [3:0] gnt;
  logic       busy;
  logic [3:0] cnt;
  logic [3:0] done;

  int tests_run;
  int tests_failed;
  int exp_cnt;

  count_sched #(.NREQ(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ev    (ev),
    .gnt   (gnt),
    .busy  (busy),
    .cnt   (cnt),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] e);
    req = r;
    ev  = e;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000);

    // Power-up reset
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt",  32'(gnt),  32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_cnt",  32'(cnt),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'h0);

    // Single run on requester 2 with ev held high
    applyStimulus(4'b0100, 4'b0100);
    @(negedge clk);
    checkOutput("single_gnt",  32'(gnt),  32'h4);
    checkOutput("single_busy", 32'(busy), 32'h1);
    for (int m = 1; m <= 16; m++) begin
      @(negedge clk);
      checkOutput("single_cnt", 32'(cnt), 32'(m - 1));
    end
    checkOutput("single_nodone", 32'(done), 32'h0);
    @(negedge clk);
    checkOutput("single_done",     32'(done), 32'h4);
    checkOutput("single_done_cnt", 32'(cnt),  32'hf);
    checkOutput("single_done_gnt", 32'(gnt),  32'h4);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("single_done_off", 32'(done), 32'h0);
    checkOutput("single_gnt_off",  32'(gnt),  32'h0);
    checkOutput("single_busy_off", 32'(busy), 32'h0);

    // Wrap: ptr is 3, req 1001 -> 1000 first, then 0001
    applyStimulus(4'b1001, 4'b1001);
    @(negedge clk);
    checkOutput("wrap_gnt3", 32'(gnt), 32'h8);
    repeat (16) @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_done3", 32'(done), 32'h8);
    @(negedge clk);
    checkOutput("wrap_gap_gnt",  32'(gnt),  32'h0);
    checkOutput("wrap_gap_busy", 32'(busy), 32'h0);
    @(negedge clk);
    checkOutput("wrap_gnt0", 32'(gnt), 32'h1);
    repeat (16) @(negedge clk);
    @(negedge clk);
    checkOutput("wrap_done0", 32'(done), 32'h1);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("wrap_end_gnt", 32'(gnt), 32'h0);

    // Gapped strobes on requester 2 (ptr is 1), foreign strobes in the gaps
    applyStimulus(4'b0100, 4'b0000);
    @(negedge clk);
    checkOutput("gap_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    exp_cnt = 0;
    checkOutput("gap_cnt_clr", 32'(cnt), 32'h0);
    for (int s = 1; s <= 15; s++) begin
      applyStimulus(4'b0100, 4'b0100);
      @(negedge clk);
      exp_cnt++;
      checkOutput("gap_cnt_inc", 32'(cnt), 32'(exp_cnt));
      applyStimulus(4'b0100, 4'b0011);
      @(negedge clk);
      checkOutput("gap_cnt_hold", 32'(cnt),  32'(exp_cnt));
      checkOutput("gap_no_done",  32'(done), 32'h0);
    end
    applyStimulus(4'b0100, 4'b0100);
    @(negedge clk);
    checkOutput("gap_done",     32'(done), 32'h4);
    checkOutput("gap_done_cnt", 32'(cnt),  32'hf);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("gap_end_gnt", 32'(gnt), 32'h0);

    // Async reset in the middle of a run on requester 1 (ptr is 3)
    applyStimulus(4'b0010, 4'b0010);
    @(negedge clk);
    checkOutput("mid_gnt", 32'(gnt), 32'h2);
    repeat (5) @(negedge clk);
    checkOutput("mid_cnt", 32'(cnt), 32'h4);
    #2;
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    #1;
    checkOutput("arst_gnt",  32'(gnt),  32'h0);
    checkOutput("arst_done", 32'(done), 32'h0);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_cnt",  32'(cnt),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin from ptr 0 with all requests held
    applyStimulus(4'b1111, 4'b1111);
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      checkOutput("rr_gnt", 32'(gnt), 32'(4'b0001 << (r % 4)));
      repeat (16) @(negedge clk);
      @(negedge clk);
      checkOutput("rr_done", 32'(done), 32'(4'b0001 << (r % 4)));
      if (r == 4) applyStimulus(4'b0000, 4'b0000);
      @(negedge clk);
      checkOutput("rr_idle_gnt",  32'(gnt),  32'h0);
      checkOutput("rr_idle_busy", 32'(busy), 32'h0);
    end

    // Drop req mid-count on requester 1 (ptr is 1)
    applyStimulus(4'b0010, 4'b0010);
    @(negedge clk);
    checkOutput("ab_gnt", 32'(gnt), 32'h2);
    repeat (6) @(negedge clk);
    checkOutput("ab_cnt5", 32'(cnt), 32'h5);
`ifdef COUNT_SCHED_ABORT_EN
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("ab_gnt_off",  32'(gnt),  32'h0);
    checkOutput("ab_no_done",  32'(done), 32'h0);
    checkOutput("ab_busy_off", 32'(busy), 32'h0);
    checkOutput("ab_cnt_keep", 32'(cnt),  32'h5);
    applyStimulus(4'b0111, 4'b0000);
    @(negedge clk);
    checkOutput("ab_next_gnt", 32'(gnt), 32'h4);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("ab_next_abort", 32'(gnt), 32'h0);
`else
    applyStimulus(4'b0000, 4'b0010);
    repeat (10) @(negedge clk);
    checkOutput("noab_cnt15", 32'(cnt), 32'hf);
    checkOutput("noab_gnt",   32'(gnt), 32'h2);
    @(negedge clk);
    checkOutput("noab_done", 32'(done), 32'h2);
    applyStimulus(4'b0000, 4'b0000);
    @(negedge clk);
    checkOutput("noab_gnt_off", 32'(gnt), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
